// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle controller: FSM states, opcodes,
// ALU operation codes, datapath select codes and the branch condition helper.
package multicycle_ctrl_pkg;

  // LUI and AUIPC share one write-back state; the IR opcode picks the source.
  typedef enum logic [3:0] {
    StInit    = 4'd0,
    StFetch   = 4'd1,
    StDecode  = 4'd2,
    StExecR   = 4'd3,
    StExecI   = 4'd4,
    StWbAlu   = 4'd5,
    StMemAddr = 4'd6,
    StMemRd   = 4'd7,
    StWbMem   = 4'd8,
    StMemWr   = 4'd9,
    StExecBr  = 4'd10,
    StBrTake  = 4'd11,
    StJal     = 4'd12,
    StWbJalr  = 4'd13,
    StWbUpper = 4'd14,
    StHalt    = 4'd15
  } state_e;

  // Opcode classes.
  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpImm    = 7'b0010011;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  // ALU operation codes.
  localparam logic [3:0] AluAdd  = 4'd0;
  localparam logic [3:0] AluSub  = 4'd1;
  localparam logic [3:0] AluSll  = 4'd2;
  localparam logic [3:0] AluSlt  = 4'd3;
  localparam logic [3:0] AluSltu = 4'd4;
  localparam logic [3:0] AluXor  = 4'd5;
  localparam logic [3:0] AluSrl  = 4'd6;
  localparam logic [3:0] AluSra  = 4'd7;
  localparam logic [3:0] AluOr   = 4'd8;
  localparam logic [3:0] AluAnd  = 4'd9;

  // How the ALU decoder should interpret func3/func7.
  localparam logic [1:0] AluClsAdd = 2'd0;
  localparam logic [1:0] AluClsSub = 2'd1;
  localparam logic [1:0] AluClsR   = 2'd2;
  localparam logic [1:0] AluClsI   = 2'd3;

  // PC source select.
  localparam logic [1:0] PcSelPlus4  = 2'd0;
  localparam logic [1:0] PcSelTarget = 2'd1;
  localparam logic [1:0] PcSelAlu    = 2'd2;

  // Register-file write data select.
  localparam logic [2:0] WdAlu   = 3'd0;
  localparam logic [2:0] WdImm   = 3'd1;
  localparam logic [2:0] WdMdr   = 3'd2;
  localparam logic [2:0] WdPc    = 3'd3;
  localparam logic [2:0] WdPcImm = 3'd4;

  // Branch outcome from flags latched after rs1 - rs2.
  function automatic logic br_taken(input logic [2:0] func3, input logic zf, input logic sf,
                                    input logic cf, input logic of);
    logic lt;
    lt = sf ^ of;
    case (func3)
      3'b000:  br_taken = zf;
      3'b001:  br_taken = ~zf;
      3'b100:  br_taken = lt;
      3'b101:  br_taken = ~lt;
      3'b110:  br_taken = cf;
      3'b111:  br_taken = ~cf;
      default: br_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_op_dec.sv
// ALU operation decoder: maps the requested class plus func3/func7 to an ALU_OP code.
module multicycle_ctrl_alu_op_dec
  import multicycle_ctrl_pkg::*;
(
  input  logic [1:0] alu_cls_i,
  input  logic [2:0] func3_i,
  input  logic [6:0] func7_i,
  output logic [3:0] alu_op_o
);

  // Only func7[5] distinguishes operations in RV32I.
  logic unused_func7;
  assign unused_func7 = ^{func7_i[6], func7_i[4:0]};

  // Decode func3; func7[5] selects SUB only for R-type, SRA for both R and I.
  always_comb begin
    alu_op_o = AluAdd;
    case (alu_cls_i)
      AluClsSub: alu_op_o = AluSub;
      AluClsR, AluClsI: begin
        case (func3_i)
          3'b000:  alu_op_o = ((alu_cls_i == AluClsR) && func7_i[5]) ? AluSub : AluAdd;
          3'b001:  alu_op_o = AluSll;
          3'b010:  alu_op_o = AluSlt;
          3'b011:  alu_op_o = AluSltu;
          3'b100:  alu_op_o = AluXor;
          3'b101:  alu_op_o = func7_i[5] ? AluSra : AluSrl;
          3'b110:  alu_op_o = AluOr;
          default: alu_op_o = AluAnd;
        endcase
      end
      default: alu_op_o = AluAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath. Moore outputs decoded from the
// current state and the stable IR fields drive every write enable and mux select.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter bit ILLEGAL_HALT = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic [6:0] func7,
  input  logic       ZF,
  input  logic       SF,
  input  logic       CF,
  input  logic       OF,
  output logic [3:0] ALU_OP,
  output logic       PC_Write,
  output logic       PC0_Write,
  output logic       IR_Write,
  output logic       Reg_Write,
  output logic       Mem_write,
  output logic [1:0] PC_s,
  output logic       rs2_imm_s,
  output logic [2:0] w_data_s,
  output logic [1:0] Size_s,
  output logic       SE_s,
  output logic [3:0] st,
  output logic [3:0] state_o,
  output logic       illegal
);

  state_e     state_q, state_d;
  logic [1:0] alu_cls;

  multicycle_ctrl_alu_op_dec u_alu_op_dec (
    .alu_cls_i (alu_cls),
    .func3_i   (func3),
    .func7_i   (func7),
    .alu_op_o  (ALU_OP)
  );

  // State register; asynchronous reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode.
  always_comb begin
    state_d   = state_q;
    alu_cls   = AluClsAdd;
    IR_Write  = 1'b0;
    PC0_Write = 1'b0;
    PC_Write  = 1'b0;
    Reg_Write = 1'b0;
    Mem_write = 1'b0;
    PC_s      = PcSelPlus4;
    rs2_imm_s = 1'b0;
    w_data_s  = WdAlu;
    Size_s    = 2'd2;
    SE_s      = 1'b0;
    st        = 4'b0000;
    illegal   = 1'b0;

    case (state_q)
      // One idle cycle so the synchronous ROM presents the word at PC.
      StInit: state_d = StFetch;

      StFetch: begin
        IR_Write  = 1'b1;
        PC0_Write = 1'b1;
        PC_Write  = 1'b1;
        PC_s      = PcSelPlus4;
        state_d   = StDecode;
      end

      StDecode: begin
        case (opcode)
          OpR:              state_d = StExecR;
          OpImm, OpJalr:    state_d = StExecI;
          OpLoad, OpStore:  state_d = StMemAddr;
          OpBranch:         state_d = StExecBr;
          OpJal:            state_d = StJal;
          OpLui, OpAuipc:   state_d = StWbUpper;
          default: begin
            // Skip mode flags the dropped instruction for this one cycle.
            illegal = ~ILLEGAL_HALT;
            state_d = ILLEGAL_HALT ? StHalt : StFetch;
          end
        endcase
      end

      StExecR: begin
        alu_cls = AluClsR;
        state_d = StWbAlu;
      end

      StExecI: begin
        rs2_imm_s = 1'b1;
        // JALR computes rs1 + imm regardless of func3.
        alu_cls   = (opcode == OpJalr) ? AluClsAdd : AluClsI;
        state_d   = (opcode == OpJalr) ? StWbJalr : StWbAlu;
      end

      StWbAlu: begin
        Reg_Write = 1'b1;
        w_data_s  = WdAlu;
        state_d   = StFetch;
      end

      StMemAddr: begin
        rs2_imm_s = 1'b1;
        Size_s    = func3[1:0];
        state_d   = (opcode == OpStore) ? StMemWr : StMemRd;
      end

      StMemRd: begin
        Size_s  = func3[1:0];
        SE_s    = ~func3[2];
        state_d = StWbMem;
      end

      StWbMem: begin
        Reg_Write = 1'b1;
        w_data_s  = WdMdr;
        Size_s    = func3[1:0];
        SE_s      = ~func3[2];
        state_d   = StFetch;
      end

      StMemWr: begin
        Mem_write = 1'b1;
        Size_s    = func3[1:0];
        case (func3[1:0])
          2'b00:   st = 4'b0001;
          2'b01:   st = 4'b0011;
          2'b10:   st = 4'b1111;
          default: st = 4'b0000;
        endcase
        state_d = StFetch;
      end

      StExecBr: begin
        alu_cls = AluClsSub;
        state_d = StBrTake;
      end

      StBrTake: begin
        if (br_taken(func3, ZF, SF, CF, OF)) begin
          PC_Write = 1'b1;
          PC_s     = PcSelTarget;
        end
        state_d = StFetch;
      end

      // PC already holds the link value (old PC + 4) after fetch.
      StJal: begin
        Reg_Write = 1'b1;
        w_data_s  = WdPc;
        PC_Write  = 1'b1;
        PC_s      = PcSelTarget;
        state_d   = StFetch;
      end

      StWbJalr: begin
        Reg_Write = 1'b1;
        w_data_s  = WdPc;
        PC_Write  = 1'b1;
        PC_s      = PcSelAlu;
        state_d   = StFetch;
      end

      StWbUpper: begin
        Reg_Write = 1'b1;
        w_data_s  = (opcode == OpLui) ? WdImm : WdPcImm;
        state_d   = StFetch;
      end

      StHalt: begin
        illegal = 1'b1;
        state_d = StHalt;
      end

      default: state_d = StInit;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Table-driven bench for multicycle_ctrl: each record holds the inputs for one
// cycle and the full expected output word for the state the FSM is in.
module tb_multicycle_ctrl;

  localparam logic [3:0] SInit = 4'd0, SFetch = 4'd1, SDecode = 4'd2, SExecR = 4'd3;
  localparam logic [3:0] SExecI = 4'd4, SWbAlu = 4'd5, SMemAddr = 4'd6, SMemRd = 4'd7;
  localparam logic [3:0] SWbMem = 4'd8, SMemWr = 4'd9, SExecBr = 4'd10, SBrTake = 4'd11;
  localparam logic [3:0] SJal = 4'd12, SWbJalr = 4'd13, SWbUpper = 4'd14, SHalt = 4'd15;

  localparam logic [6:0] R = 7'b0110011, IMM = 7'b0010011, LD = 7'b0000011;
  localparam logic [6:0] SW = 7'b0100011, BR = 7'b1100011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, LUI = 7'b0110111, AUIPC = 7'b0010111;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] opcode, func7;
  logic [2:0] func3;
  logic       ZF, SF, CF, OF;
  logic [3:0] ALU_OP, st, state_o;
  logic       PC_Write, PC0_Write, IR_Write, Reg_Write, Mem_write, rs2_imm_s, SE_s, illegal;
  logic [1:0] PC_s, Size_s;
  logic [2:0] w_data_s;

  multicycle_ctrl #(.ILLEGAL_HALT(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .func3     (func3),
    .func7     (func7),
    .ZF        (ZF),
    .SF        (SF),
    .CF        (CF),
    .OF        (OF),
    .ALU_OP    (ALU_OP),
    .PC_Write  (PC_Write),
    .PC0_Write (PC0_Write),
    .IR_Write  (IR_Write),
    .Reg_Write (Reg_Write),
    .Mem_write (Mem_write),
    .PC_s      (PC_s),
    .rs2_imm_s (rs2_imm_s),
    .w_data_s  (w_data_s),
    .Size_s    (Size_s),
    .SE_s      (SE_s),
    .st        (st),
    .state_o   (state_o),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [3:0]  flg;   // {ZF, SF, CF, OF}
    logic [26:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  int          vec_no = 0;
  logic [6:0]  cur_op;
  logic [2:0]  cur_f3;
  logic [6:0]  cur_f7;
  logic [3:0]  cur_flg;

  // Expected word: {state, {IR,PC0,PC,Reg,Mem} writes, ALU_OP, PC_s, rs2_imm_s,
  // w_data_s, Size_s, SE_s, st, illegal}.
  function automatic logic [26:0] pk(input logic [3:0] s, input logic [4:0] we,
                                     input logic [3:0] alu, input logic [1:0] pcs,
                                     input logic rs2, input logic [2:0] wds,
                                     input logic [1:0] size, input logic se,
                                     input logic [3:0] stb, input logic ill);
    return {s, we, alu, pcs, rs2, wds, size, se, stb, ill};
  endfunction

  function automatic logic [26:0] actual();
    return {state_o, IR_Write, PC0_Write, PC_Write, Reg_Write, Mem_write, ALU_OP, PC_s,
            rs2_imm_s, w_data_s, Size_s, SE_s, st, illegal};
  endfunction

  task automatic insn(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [3:0] flg);
    cur_op = op; cur_f3 = f3; cur_f7 = f7; cur_flg = flg;
  endtask

  task automatic add(input logic rst, input logic [26:0] exp);
    vec_t v;
    v.rst = rst; v.op = cur_op; v.f3 = cur_f3; v.f7 = cur_f7; v.flg = cur_flg; v.exp = exp;
    vecs.push_back(v);
  endtask

  // A state with no writes and every select at its idle value.
  task automatic idle(input logic rst, input logic [3:0] s);
    add(rst, pk(s, 5'b00000, 4'd0, 2'd0, 1'b0, 3'd0, 2'd2, 1'b0, 4'b0000, 1'b0));
  endtask

  task automatic fd();
    add(1'b0, pk(SFetch, 5'b11100, 4'd0, 2'd0, 1'b0, 3'd0, 2'd2, 1'b0, 4'b0000, 1'b0));
    idle(1'b0, SDecode);
  endtask

  task automatic check(input string name, input logic [26:0] exp);
    logic [26:0] got;
    got = actual();
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %h want %h (diff %h)", name, vec_no, got, exp, got ^ exp);
    end
  endtask

  task automatic step(input vec_t v);
    reset = v.rst;
    opcode = v.op; func3 = v.f3; func7 = v.f7;
    {ZF, SF, CF, OF} = v.flg;
    #1;
    check("table", v.exp);
    vec_no++;
    @(posedge clk);
    #2;
  endtask

  task automatic alu_insn(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [3:0] s, input logic [3:0] alu, input logic rs2);
    insn(op, f3, f7, 4'b0000);
    fd();
    add(1'b0, pk(s, 5'b00000, alu, 2'd0, rs2, 3'd0, 2'd2, 1'b0, 4'b0000, 1'b0));
    add(1'b0, pk(SWbAlu, 5'b00010, 4'd0, 2'd0, 1'b0, 3'd0, 2'd2, 1'b0, 4'b0000, 1'b0));
  endtask

  task automatic branch(input logic [2:0] f3, input logic [3:0] flg, input logic taken);
    insn(BR, f3, 7'h00, flg);
    fd();
    add(1'b0, pk(SExecBr, 5'b00000, 4'd1, 2'd0, 1'b0, 3'd0, 2'd2, 1'b0, 4'b0000, 1'b0));
    if (taken) add(1'b0, pk(SBrTake, 5'b00100, 4'd0, 2'd1, 1'b0, 3'd0, 2'd2, 1'b0, 4'b0, 1'b0));
    else       idle(1'b0, SBrTake);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    opcode = R; func3 = 3'd0; func7 = 7'd0;
    {ZF, SF, CF, OF} = 4'b0000;

    // Reset held three cycles, then one INIT cycle.
    insn(R, 3'b000, 7'h00, 4'b0000);
    for (int i = 0; i < 3; i++) idle(1'b1, SInit);
    idle(1'b0, SInit);

    // R-type and I-type ALU ops.
    alu_insn(R,   3'b000, 7'h00, SExecR, 4'd0, 1'b0);   // add
    alu_insn(R,   3'b000, 7'h20, SExecR, 4'd1, 1'b0);   // sub
    alu_insn(R,   3'b101, 7'h20, SExecR, 4'd7, 1'b0);   // sra
    alu_insn(R,   3'b010, 7'h00, SExecR, 4'd3, 1'b0);   // slt
    alu_insn(IMM, 3'b101, 7'h20, SExecI, 4'd7, 1'b1);   // srai
    alu_insn(IMM, 3'b101, 7'h00, SExecI, 4'd6, 1'b1);   // srli
    alu_insn(IMM, 3'b100, 7'h20, SExecI, 4'd5, 1'b1);   // xori, func7 ignored
    alu_insn(IMM, 3'b000, 7'h20, SExecI, 4'd0, 1'b1);   // addi never becomes sub

    // Stores: sb, sh.
    insn(SW, 3'b000, 7'h00, 4'b0000);
    fd();
    add(1'b0, pk(SMemAddr, 5'b00000, 4'd0, 2'd0, 1'b1, 3'd0, 2'd0, 1'b0, 4'b0000, 1'b0));
    add(1'b0, pk(SMemWr,   5'b00001, 4'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0, 4'b0001, 1'b0));
    insn(SW, 3'b001, 7'h00, 4'b0000);
    fd();
    add(1'b0, pk(SMemAddr, 5'b00000, 4'd0, 2'd0, 1'b1, 3'd0, 2'd1, 1'b0, 4'b0000, 1'b0));
    add(1'b0, pk(SMemWr,   5'b00001, 4'd0, 2'd0, 1'b0, 3'd0, 2'd1, 1'b0, 4'b0011, 1'b0));

    // Loads: lw (sign-extend), lbu (zero-extend).
    insn(LD, 3'b010, 7'h00, 4'b0000);
    fd();
    add(1'b0, pk(SMemAddr, 5'b00000, 4'd0, 2'd0, 1'b1, 3'd0, 2'd2, 1'b0, 4'b0000, 1'b0));
    add(1'b0, pk(SMemRd,   5'b00000, 4'd0, 2'd0, 1'b0, 3'd0, 2'd2, 1'b1, 4'b0000, 1'b0));
    add(1'b0, pk(SWbMem,   5'b00010, 4'd0, 2'd0, 1'b0, 3'd2, 2'd2, 1'b1, 4'b0000, 1'b0));
    insn(LD, 3'b100, 7'h00, 4'b0000);
    fd();
    add(1'b0, pk(SMemAddr, 5'b00000, 4'd0, 2'd0, 1'b1, 3'd0, 2'd0, 1'b0, 4'b0000, 1'b0));
    add(1'b0, pk(SMemRd,   5'b00000, 4'd0, 2'd0, 1'b0, 3'd0, 2'd0, 1'b0, 4'b0000, 1'b0));
    add(1'b0, pk(SWbMem,   5'b00010, 4'd0, 2'd0, 1'b0, 3'd2, 2'd0, 1'b0, 4'b0000, 1'b0));

    // Branches: flags are {ZF, SF, CF, OF}.
    branch(3'b110, 4'b0010, 1'b1);  // bltu, CF=1
    branch(3'b101, 4'b0100, 1'b0);  // bge, SF=1 OF=0
    branch(3'b100, 4'b0100, 1'b1);  // blt, SF=1 OF=0
    branch(3'b001, 4'b1000, 1'b0);  // bne, ZF=1
    branch(3'b000, 4'b1000, 1'b1);  // beq, ZF=1
    branch(3'b111, 4'b0000, 1'b1);  // bgeu, CF=0

    // Jumps and upper-immediate forms.
    insn(JAL, 3'b000, 7'h00, 4'b0000);
    fd();
    add(1'b0, pk(SJal, 5'b00110, 4'd0, 2'd1, 1'b0, 3'd3, 2'd2, 1'b0, 4'b0000, 1'b0));
    insn(JALR, 3'b000, 7'h20, 4'b0000);
    fd();
    add(1'b0, pk(SExecI,  5'b00000, 4'd0, 2'd0, 1'b1, 3'd0, 2'd2, 1'b0, 4'b0000, 1'b0));
    add(1'b0, pk(SWbJalr, 5'b00110, 4'd0, 2'd2, 1'b0, 3'd3, 2'd2, 1'b0, 4'b0000, 1'b0));
    insn(LUI, 3'b000, 7'h00, 4'b0000);
    fd();
    add(1'b0, pk(SWbUpper, 5'b00010, 4'd0, 2'd0, 1'b0, 3'd1, 2'd2, 1'b0, 4'b0000, 1'b0));
    insn(AUIPC, 3'b000, 7'h00, 4'b0000);
    fd();
    add(1'b0, pk(SWbUpper, 5'b00010, 4'd0, 2'd0, 1'b0, 3'd4, 2'd2, 1'b0, 4'b0000, 1'b0));

    // sw up to its address cycle; the write cycle is checked by hand below.
    insn(SW, 3'b010, 7'h00, 4'b0000);
    fd();
    add(1'b0, pk(SMemAddr, 5'b00000, 4'd0, 2'd0, 1'b1, 3'd0, 2'd2, 1'b0, 4'b0000, 1'b0));

    @(posedge clk);
    #2;
    foreach (vecs[i]) step(vecs[i]);

    // Reset asserted in the middle of MEM_WR must kill the strobes at once.
    #1;
    check("sw_mem_wr", pk(SMemWr, 5'b00001, 4'd0, 2'd0, 1'b0, 3'd0, 2'd2, 1'b0, 4'b1111, 1'b0));
    reset = 1'b1;
    #1;
    check("reset_mid_wr", pk(SInit, 5'b00000, 4'd0, 2'd0, 1'b0, 3'd0, 2'd2, 1'b0, 4'b0000, 1'b0));
    @(posedge clk);
    #2;

    // Illegal opcode parks the FSM in HALT with no writes, even if IR changes.
    vecs.delete();
    insn(7'h7F, 3'b000, 7'h00, 4'b0000);
    idle(1'b1, SInit);
    idle(1'b0, SInit);
    fd();
    for (int i = 0; i < 3; i++)
      add(1'b0, pk(SHalt, 5'b00000, 4'd0, 2'd0, 1'b0, 3'd0, 2'd2, 1'b0, 4'b0000, 1'b1));
    insn(R, 3'b000, 7'h00, 4'b0000);
    for (int i = 0; i < 2; i++)
      add(1'b0, pk(SHalt, 5'b00000, 4'd0, 2'd0, 1'b0, 3'd0, 2'd2, 1'b0, 4'b0000, 1'b1));
    foreach (vecs[i]) step(vecs[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
